// File: rtl/io_bus_master.sv
// MMIO initiator: turns MEM-stage load/store requests into timed IO_BUS strobes.
// Optional one-entry posted-write buffer enabled by defining IO_POSTED_WRITE_EN.
module io_bus_master #(
    parameter logic [15:0] IO_HI   = 16'hFFFF,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned WR_HOLD = 1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req_valid,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_stall,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic [15:0] o_io_addr,
    output logic [31:0] o_io_dout,
    output logic        o_io_we,
    output logic        o_io_rd,
    input  logic [31:0] i_io_din
);

    localparam int unsigned MaxLat = (RD_LAT > WR_HOLD) ? RD_LAT : WR_HOLD;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
    localparam logic [CntW-1:0] RdInit = CntW'(RD_LAT - 1);
    localparam logic [CntW-1:0] WrInit = CntW'(WR_HOLD - 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e            r_state,   w_state_nxt;
    logic [CntW-1:0]   r_cnt,     w_cnt_nxt;
    logic              r_io_we,   w_io_we_nxt;
    logic              r_io_rd,   w_io_rd_nxt;
    logic [15:0]       r_io_addr, w_io_addr_nxt;
    logic [31:0]       r_io_dout, w_io_dout_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic              r_rsp_err,   w_rsp_err_nxt;
    logic [31:0]       r_rsp_rdata, w_rsp_rdata_nxt;

    logic w_err;
    logic w_idle;
    logic w_req_ready;
    logic w_accept;

`ifdef IO_POSTED_WRITE_EN
    logic        r_buf_valid, w_buf_valid_nxt;
    logic [15:0] r_buf_addr,  w_buf_addr_nxt;
    logic [31:0] r_buf_wdata, w_buf_wdata_nxt;
`endif

    assign w_err  = (i_req_addr[31:16] != IO_HI) || (i_req_addr[1:0] != 2'b00);
    assign w_idle = (r_state == StIdle);

`ifdef IO_POSTED_WRITE_EN
    // Good stores only need a free buffer slot; everything else waits for full quiescence.
    assign w_req_ready = (i_req_we && !w_err) ? !r_buf_valid : (!r_buf_valid && w_idle);
`else
    assign w_req_ready = w_idle;
`endif

    assign w_accept = i_req_valid && w_req_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_io_we_nxt     = r_io_we;
        w_io_rd_nxt     = r_io_rd;
        w_io_addr_nxt   = r_io_addr;
        w_io_dout_nxt   = r_io_dout;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = 32'h0;
`ifdef IO_POSTED_WRITE_EN
        w_buf_valid_nxt = r_buf_valid;
        w_buf_addr_nxt  = r_buf_addr;
        w_buf_wdata_nxt = r_buf_wdata;
`endif

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end else if (i_req_we) begin
                        w_state_nxt   = StWrite;
                        w_cnt_nxt     = WrInit;
                        w_io_we_nxt   = 1'b1;
                        w_io_addr_nxt = i_req_addr[15:0];
                        w_io_dout_nxt = i_req_wdata;
`ifdef IO_POSTED_WRITE_EN
                        w_rsp_valid_nxt = 1'b1;
`endif
                    end else begin
                        w_state_nxt   = StRead;
                        w_cnt_nxt     = RdInit;
                        w_io_rd_nxt   = 1'b1;
                        w_io_addr_nxt = i_req_addr[15:0];
                    end
                end
            end
            StWrite: begin
                if (r_cnt == '0) begin
                    w_state_nxt = StIdle;
                    w_io_we_nxt = 1'b0;
`ifdef IO_POSTED_WRITE_EN
                    w_rsp_valid_nxt = 1'b0;
`else
                    w_rsp_valid_nxt = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            StRead: begin
                if (r_cnt == '0) begin
                    w_state_nxt     = StIdle;
                    w_io_rd_nxt     = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = i_io_din;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

`ifdef IO_POSTED_WRITE_EN
        // Store arriving while the bus is busy is parked and acked immediately.
        if (w_accept && i_req_we && !w_err && !w_idle) begin
            w_buf_valid_nxt = 1'b1;
            w_buf_addr_nxt  = i_req_addr[15:0];
            w_buf_wdata_nxt = i_req_wdata;
            w_rsp_valid_nxt = 1'b1;
        end
        if (w_idle && r_buf_valid) begin
            w_state_nxt     = StWrite;
            w_cnt_nxt       = WrInit;
            w_io_we_nxt     = 1'b1;
            w_io_addr_nxt   = r_buf_addr;
            w_io_dout_nxt   = r_buf_wdata;
            w_buf_valid_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_io_we     <= 1'b0;
            r_io_rd     <= 1'b0;
            r_io_addr   <= 16'h0;
            r_io_dout   <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
`ifdef IO_POSTED_WRITE_EN
            r_buf_valid <= 1'b0;
            r_buf_addr  <= 16'h0;
            r_buf_wdata <= 32'h0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_io_we     <= w_io_we_nxt;
            r_io_rd     <= w_io_rd_nxt;
            r_io_addr   <= w_io_addr_nxt;
            r_io_dout   <= w_io_dout_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
`ifdef IO_POSTED_WRITE_EN
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_addr  <= w_buf_addr_nxt;
            r_buf_wdata <= w_buf_wdata_nxt;
`endif
        end
    end

    assign o_req_ready = w_req_ready;
    assign o_stall     = i_req_valid && !w_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_io_addr   = r_io_addr;
    assign o_io_dout   = r_io_dout;
    assign o_io_we     = r_io_we;
    assign o_io_rd     = r_io_rd;

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master (WR_HOLD=1, RD_LAT=2); cycle n = period after accept edge n.
module tb_io_bus_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;

    int n_chk  = 0;
    int n_pass = 0;

    io_bus_master #(
        .IO_HI  (16'hFFFF),
        .RD_LAT (2),
        .WR_HOLD(1)
    ) u_dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_req_valid(req_valid),
        .i_req_we   (req_we),
        .i_req_addr (req_addr),
        .i_req_wdata(req_wdata),
        .o_req_ready(req_ready),
        .o_stall    (stall),
        .o_rsp_valid(rsp_valid),
        .o_rsp_rdata(rsp_rdata),
        .o_rsp_err  (rsp_err),
        .o_io_addr  (io_addr),
        .o_io_dout  (io_dout),
        .o_io_we    (io_we),
        .o_io_rd    (io_rd),
        .i_io_din   (io_din)
    );

    always #5 clk = ~clk;

    // Strobes must never overlap, checked every cycle.
    always @(negedge clk) begin
        if (io_we && io_rd) $display("FAIL strobe_overlap: io_we=%0b io_rd=%0b, required not both", io_we, io_rd);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        io_din    = 32'h0;
        tick();
        tick();
        chk("rst_io_we",     32'(io_we),     32'h0);
        chk("rst_io_rd",     32'(io_rd),     32'h0);
        chk("rst_io_addr",   32'(io_addr),   32'h0);
        chk("rst_io_dout",   io_dout,        32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_rsp_err",   32'(rsp_err),   32'h0);
        rstn = 1'b1;
        tick();
        chk("rst_ready", 32'(req_ready), 32'h1);

`ifndef IO_POSTED_WRITE_EN
        // Store.
        req(1'b1, 32'hFFFF_0010, 32'h0000_00A5);
        chk("st_c0_stall", 32'(stall), 32'h0);
        tick();
        req_valid = 1'b0;
        chk("st_c1_we",    32'(io_we),     32'h1);
        chk("st_c1_addr",  32'(io_addr),   32'h0010);
        chk("st_c1_dout",  io_dout,        32'h0000_00A5);
        chk("st_c1_rsp",   32'(rsp_valid), 32'h0);
        chk("st_c1_ready", 32'(req_ready), 32'h0);
        tick();
        chk("st_c2_rsp",   32'(rsp_valid), 32'h1);
        chk("st_c2_err",   32'(rsp_err),   32'h0);
        chk("st_c2_we",    32'(io_we),     32'h0);
        chk("st_c2_rdata", rsp_rdata,      32'h0);
        // Load accepted in the store's response cycle.
        req(1'b0, 32'hFFFF_0020, 32'h0);
        chk("b2b_ready", 32'(req_ready), 32'h1);
        tick();
        chk("ld_c1_rd",    32'(io_rd),   32'h1);
        chk("ld_c1_we",    32'(io_we),   32'h0);
        chk("ld_c1_addr",  32'(io_addr), 32'h0020);
        chk("ld_c1_stall", 32'(stall),   32'h1);
        io_din   = 32'hDEAD_BEEF;
        req_addr = 32'hFFFF_0040;
        tick();
        chk("ld_c2_rd",    32'(io_rd),     32'h1);
        chk("ld_c2_stall", 32'(stall),     32'h1);
        chk("ld_c2_addr",  32'(io_addr),   32'h0020);
        chk("ld_c2_rsp",   32'(rsp_valid), 32'h0);
        io_din = 32'h0000_1234;
        tick();
        chk("ld_c3_rsp",   32'(rsp_valid), 32'h1);
        chk("ld_c3_rdata", rsp_rdata,      32'h0000_1234);
        chk("ld_c3_err",   32'(rsp_err),   32'h0);
        chk("ld_c3_rd",    32'(io_rd),     32'h0);
        req_valid = 1'b0;
        tick();
        chk("ld_c4_rsp",   32'(rsp_valid), 32'h0);
        chk("ld_c4_rdata", rsp_rdata,      32'h0);

        // Out-of-window load, then misaligned store.
        req(1'b0, 32'h0000_1000, 32'h0);
        tick();
        chk("err1_rsp",   32'(rsp_valid), 32'h1);
        chk("err1_err",   32'(rsp_err),   32'h1);
        chk("err1_rdata", rsp_rdata,      32'h0);
        chk("err1_rd",    32'(io_rd),     32'h0);
        req(1'b1, 32'hFFFF_0012, 32'h5555_5555);
        tick();
        req_valid = 1'b0;
        chk("err2_rsp",  32'(rsp_valid), 32'h1);
        chk("err2_err",  32'(rsp_err),   32'h1);
        chk("err2_we",   32'(io_we),     32'h0);
        chk("err2_addr", 32'(io_addr),   32'h0020);
        tick();
        chk("err2_done", 32'(rsp_valid), 32'h0);

        // Reset in cycle 1 of a load.
        req(1'b0, 32'hFFFF_0030, 32'h0);
        tick();
        chk("rl_c1_rd", 32'(io_rd), 32'h1);
        rstn      = 1'b0;
        req_valid = 1'b0;
        tick();
        chk("rl_rd",   32'(io_rd),     32'h0);
        chk("rl_rsp",  32'(rsp_valid), 32'h0);
        chk("rl_addr", 32'(io_addr),   32'h0);
        rstn = 1'b1;
        tick();
        chk("rl_rsp2", 32'(rsp_valid), 32'h0);
        io_din = 32'h0000_5A5A;
        req(1'b0, 32'hFFFF_0004, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("rl_ld_rd",   32'(io_rd),   32'h1);
        chk("rl_ld_addr", 32'(io_addr), 32'h0004);
        tick();
        tick();
        chk("rl_ld_rsp",   32'(rsp_valid), 32'h1);
        chk("rl_ld_rdata", rsp_rdata,      32'h0000_5A5A);
`else
        // Three back-to-back stores through the posted buffer, then a load.
        req(1'b1, 32'hFFFF_0100, 32'h1);
        tick();
        chk("pw_c1_rsp",  32'(rsp_valid), 32'h1);
        chk("pw_c1_we",   32'(io_we),     32'h1);
        chk("pw_c1_dout", io_dout,        32'h1);
        req(1'b1, 32'hFFFF_0104, 32'h2);
        chk("pw_c1_ready", 32'(req_ready), 32'h1);
        tick();
        chk("pw_c2_rsp", 32'(rsp_valid), 32'h1);
        chk("pw_c2_we",  32'(io_we),     32'h0);
        req(1'b1, 32'hFFFF_0108, 32'h3);
        chk("pw_c2_stall", 32'(stall), 32'h1);
        tick();
        chk("pw_c3_rsp",   32'(rsp_valid), 32'h0);
        chk("pw_c3_we",    32'(io_we),     32'h1);
        chk("pw_c3_dout",  io_dout,        32'h2);
        chk("pw_c3_stall", 32'(stall),     32'h0);
        tick();
        chk("pw_c4_rsp", 32'(rsp_valid), 32'h1);
        chk("pw_c4_we",  32'(io_we),     32'h0);
        req(1'b0, 32'hFFFF_0200, 32'h0);
        chk("pw_c4_stall", 32'(stall), 32'h1);
        tick();
        chk("pw_c5_we",    32'(io_we),   32'h1);
        chk("pw_c5_dout",  io_dout,      32'h3);
        chk("pw_c5_addr",  32'(io_addr), 32'h0108);
        chk("pw_c5_rd",    32'(io_rd),   32'h0);
        chk("pw_c5_stall", 32'(stall),   32'h1);
        tick();
        chk("pw_c6_we",    32'(io_we), 32'h0);
        chk("pw_c6_stall", 32'(stall), 32'h0);
        tick();
        req_valid = 1'b0;
        chk("pw_c7_rd", 32'(io_rd), 32'h1);
        io_din = 32'h0000_0077;
        tick();
        tick();
        chk("pw_ld_rsp",   32'(rsp_valid), 32'h1);
        chk("pw_ld_rdata", rsp_rdata,      32'h0000_0077);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
